// File: rtl/seven_seg_history_display_pkg.sv
// Shared definitions for the seven-segment history display.
//
// Contents:
//   SEG_BLANK  - active-low pattern with every segment off
//   SEG_DASH   - active-low pattern with only segment g lit
//   seg_encode - maps a decimal digit 0..9 to its active-low segment pattern
//                (bit0 = a ... bit6 = g); any other value gives a blank digit
package seg_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    function automatic logic [6:0] seg_encode(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'h40;
            4'd1:    pattern = 7'h79;
            4'd2:    pattern = 7'h24;
            4'd3:    pattern = 7'h30;
            4'd4:    pattern = 7'h19;
            4'd5:    pattern = 7'h12;
            4'd6:    pattern = 7'h02;
            4'd7:    pattern = 7'h78;
            4'd8:    pattern = 7'h00;
            4'd9:    pattern = 7'h10;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/seven_seg_history_display_if.sv
// Bundle of the classifier-side inputs and display-side outputs of the
// seven-segment history display.
//
// Signals:
//   result_valid - single-cycle strobe qualifying result_in
//   result_in    - classifier digit, legal range 0..9
//   clear        - synchronous request to empty the history
//   busy         - level; while high every digit shows a dash
//   seg          - active-low segments, bit0 = a ... bit6 = g
//   dp           - active-low decimal point
//   an           - active-low one-hot digit enable, an[0] = rightmost digit
//   fill_count   - number of valid history entries
//   bad_input    - sticky flag for rejected out-of-range results
//
// Modports: master drives the inputs and observes the outputs; slave is the
// display block itself.
interface seven_seg_history_display_if #(
    parameter int NUM_DIGITS = 4
);

    localparam int FILL_W = $clog2(NUM_DIGITS + 1);

    logic                  result_valid;
    logic [3:0]            result_in;
    logic                  clear;
    logic                  busy;
    logic [6:0]            seg;
    logic                  dp;
    logic [NUM_DIGITS-1:0] an;
    logic [FILL_W-1:0]     fill_count;
    logic                  bad_input;

    modport master (
        output result_valid, result_in, clear, busy,
        input  seg, dp, an, fill_count, bad_input
    );

    modport slave (
        input  result_valid, result_in, clear, busy,
        output seg, dp, an, fill_count, bad_input
    );

endinterface

// File: rtl/seven_seg_history_display_scan_timer.sv
// Scan timing for the multiplexed display: a prescaler that holds each digit
// selected for REFRESH_DIV clock cycles, and a digit selector that steps
// 0..NUM_DIGITS-1 and wraps.
//
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   digit_sel - index of the digit currently being driven
module seg_scan_timer
    import seg_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 4,
    localparam int SEL_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [SEL_W-1:0] digit_sel
);

    localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PRE_W-1:0] prescale;
    logic             tick;

    // With REFRESH_DIV = 1 the prescaler is stuck at 0, so tick is always high
    // and the selector advances every cycle.
    assign tick = (prescale == PRE_W'(REFRESH_DIV - 1));

    // Explicit wrap at NUM_DIGITS-1 so non-power-of-two digit counts never
    // reach an index without a physical digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale  <= '0;
            digit_sel <= '0;
        end else if (tick) begin
            prescale  <= '0;
            digit_sel <= (digit_sel == SEL_W'(NUM_DIGITS - 1)) ? '0
                                                                : digit_sel + SEL_W'(1);
        end else begin
            prescale  <= prescale + PRE_W'(1);
        end
    end

endmodule

// File: rtl/seven_seg_history_display.sv
// Multiplexed seven-segment driver showing the history of the last
// NUM_DIGITS classifier results. The newest result sits on the rightmost
// digit (an[0]); older results move left and the oldest falls off once the
// history is full. Unfilled digits are blank, busy shows dashes everywhere,
// and the rightmost decimal point flashes for FLASH_CYCLES after each result.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset
//   disp - slave side of seven_seg_history_display_if (result strobe/data,
//          clear, busy in; seg, dp, an, fill_count, bad_input out)
//
// All outputs come from registers; no input reaches a pin combinationally.
module seven_seg_history_display
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int FLASH_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst,
    seven_seg_history_display_if.slave disp
);

    localparam int FILL_W  = $clog2(NUM_DIGITS + 1);
    localparam int SEL_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);

    logic [3:0]            hist [NUM_DIGITS];
    logic [FILL_W-1:0]     fill_count;
    logic [FLASH_W-1:0]    flash_cnt;
    logic                  bad_input;
    logic [SEL_W-1:0]      digit_sel;
    logic                  accept;
    logic                  reject;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] an_next;
    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [NUM_DIGITS-1:0] an_q;

    seg_scan_timer #(
        .REFRESH_DIV (REFRESH_DIV),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_scan (
        .clk       (clk),
        .rst       (rst),
        .digit_sel (digit_sel)
    );

    // clear wins over a simultaneous strobe, which is then neither accepted
    // nor flagged as bad.
    assign accept = disp.result_valid && !disp.clear && (disp.result_in <= 4'd9);
    assign reject = disp.result_valid && !disp.clear && (disp.result_in >  4'd9);

    // History is left alone on clear; fill_count alone decides what is shown.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) hist[i] <= '0;
        end else if (accept) begin
            hist[0] <= disp.result_in;
            for (int i = 1; i < NUM_DIGITS; i++) hist[i] <= hist[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_count <= '0;
            bad_input  <= 1'b0;
        end else if (disp.clear) begin
            fill_count <= '0;
            bad_input  <= 1'b0;
        end else begin
            if (accept && (fill_count != FILL_W'(NUM_DIGITS)))
                fill_count <= fill_count + FILL_W'(1);
            if (reject)
                bad_input <= 1'b1;
        end
    end

    // Each accepted result restarts the flash window from the top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            flash_cnt <= '0;
        else if (disp.clear)
            flash_cnt <= '0;
        else if (accept)
            flash_cnt <= FLASH_W'(FLASH_CYCLES);
        else if (flash_cnt != '0)
            flash_cnt <= flash_cnt - FLASH_W'(1);
    end

    always_comb begin
        an_next            = '1;
        an_next[digit_sel] = 1'b0;
        seg_next           = SEG_BLANK;
        if (disp.busy)
            seg_next = SEG_DASH;
        else if (FILL_W'(digit_sel) < fill_count)
            seg_next = seg_encode(hist[digit_sel]);
        dp_next = !((digit_sel == '0) && (flash_cnt != '0) && !disp.busy);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else begin
            seg_q <= seg_next;
            dp_q  <= dp_next;
            an_q  <= an_next;
        end
    end

    assign disp.seg        = seg_q;
    assign disp.dp         = dp_q;
    assign disp.an         = an_q;
    assign disp.fill_count = fill_count;
    assign disp.bad_input  = bad_input;

endmodule

// File: tb/tb_seven_seg_history_display.sv
// Self-checking bench for seven_seg_history_display.
// Main instance: NUM_DIGITS=4, REFRESH_DIV=2, FLASH_CYCLES=10.
// Second instance: NUM_DIGITS=3, REFRESH_DIV=1, used for the scan-wrap check.
module tb_seven_seg_history_display;

    localparam int NUM_DIGITS   = 4;
    localparam int REFRESH_DIV  = 2;
    localparam int FLASH_CYCLES = 10;
    localparam int NUM_VECS     = 17;

    typedef struct {
        logic       valid;
        logic [3:0] value;
        logic       clr;
        logic       bsy;
        int         exp_fill;
        logic       exp_bad;
        logic [6:0] s0;
        logic [6:0] s1;
        logic [6:0] s2;
        logic [6:0] s3;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc;
    int         vectors_applied = 0;
    int         miscompares = 0;
    logic [6:0] exp_q [$];
    vec_t       vecs [NUM_VECS];

    seven_seg_history_display_if #(.NUM_DIGITS(4)) disp_bus ();
    seven_seg_history_display_if #(.NUM_DIGITS(3)) wrap_bus ();

    seven_seg_history_display #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .FLASH_CYCLES (FLASH_CYCLES)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (disp_bus)
    );

    seven_seg_history_display #(
        .NUM_DIGITS   (3),
        .REFRESH_DIV  (1),
        .FLASH_CYCLES (10)
    ) dut_wrap (
        .clk  (clk),
        .rst  (rst),
        .disp (wrap_bus)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; drives the independent scan-phase model.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] an4(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    function automatic logic [2:0] an3(input int d);
        logic [2:0] one;
        one = 3'b001;
        return ~(one << d);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors_applied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Drives one table row for a single clock and queues its expected digits.
    task automatic applyStimulus(input vec_t v);
        disp_bus.result_valid = v.valid;
        disp_bus.result_in    = v.value;
        disp_bus.clear        = v.clr;
        disp_bus.busy         = v.bsy;
        exp_q.push_back(v.s0);
        exp_q.push_back(v.s1);
        exp_q.push_back(v.s2);
        exp_q.push_back(v.s3);
        @(negedge clk);
        disp_bus.result_valid = 1'b0;
        disp_bus.clear        = 1'b0;
        disp_bus.result_in    = 4'd0;
    endtask

    // Waits for each digit to be selected and compares it with the queue head.
    task automatic scanCheck(input string name, input logic bsy);
        logic [6:0] exp;
        int         waited;
        @(negedge clk);
        for (int d = 0; d < NUM_DIGITS; d++) begin
            waited = 0;
            while (disp_bus.an !== an4(d) && waited < 4 * NUM_DIGITS * REFRESH_DIV) begin
                @(negedge clk);
                waited++;
            end
            exp = exp_q.pop_front();
            if (disp_bus.an !== an4(d)) begin
                checkOutput($sformatf("%s an%0d select timeout", name, d), disp_bus.an, an4(d));
            end else begin
                checkOutput($sformatf("%s seg digit%0d", name, d), disp_bus.seg, exp);
                if (bsy) checkOutput($sformatf("%s busy dp digit%0d", name, d), disp_bus.dp, 1);
            end
        end
    endtask

    initial begin
        int   waited;
        int   exp_digit;
        logic exp_dp;

        disp_bus.result_valid = 1'b0;
        disp_bus.result_in    = 4'd0;
        disp_bus.clear        = 1'b0;
        disp_bus.busy         = 1'b0;
        wrap_bus.result_valid = 1'b0;
        wrap_bus.result_in    = 4'd0;
        wrap_bus.clear        = 1'b0;
        wrap_bus.busy         = 1'b0;

        //               valid  value  clr   bsy  fill bad   s0     s1     s2     s3
        vecs[0]  = '{1'b1, 4'd3, 1'b0, 1'b0, 1, 1'b0, 7'h30, 7'h7F, 7'h7F, 7'h7F};
        vecs[1]  = '{1'b1, 4'd7, 1'b0, 1'b0, 2, 1'b0, 7'h78, 7'h30, 7'h7F, 7'h7F};
        vecs[2]  = '{1'b1, 4'd1, 1'b0, 1'b0, 3, 1'b0, 7'h79, 7'h78, 7'h30, 7'h7F};
        vecs[3]  = '{1'b1, 4'd5, 1'b0, 1'b0, 4, 1'b0, 7'h12, 7'h79, 7'h78, 7'h30};
        vecs[4]  = '{1'b1, 4'd9, 1'b0, 1'b0, 4, 1'b0, 7'h10, 7'h12, 7'h79, 7'h78};
        vecs[5]  = '{1'b1, 4'hC, 1'b0, 1'b0, 4, 1'b1, 7'h10, 7'h12, 7'h79, 7'h78};
        vecs[6]  = '{1'b1, 4'd2, 1'b1, 1'b0, 0, 1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
        vecs[7]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1, 1'b0, 7'h79, 7'h7F, 7'h7F, 7'h7F};
        vecs[8]  = '{1'b1, 4'd2, 1'b0, 1'b0, 2, 1'b0, 7'h24, 7'h79, 7'h7F, 7'h7F};
        vecs[9]  = '{1'b0, 4'd0, 1'b0, 1'b1, 2, 1'b0, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        vecs[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 2, 1'b0, 7'h24, 7'h79, 7'h7F, 7'h7F};
        vecs[11] = '{1'b1, 4'd0, 1'b0, 1'b0, 3, 1'b0, 7'h40, 7'h24, 7'h79, 7'h7F};
        vecs[12] = '{1'b1, 4'd6, 1'b0, 1'b0, 4, 1'b0, 7'h02, 7'h40, 7'h24, 7'h79};
        vecs[13] = '{1'b1, 4'd4, 1'b0, 1'b0, 4, 1'b0, 7'h19, 7'h02, 7'h40, 7'h24};
        vecs[14] = '{1'b1, 4'd8, 1'b0, 1'b0, 4, 1'b0, 7'h00, 7'h19, 7'h02, 7'h40};
        vecs[15] = '{1'b1, 4'hF, 1'b0, 1'b0, 4, 1'b1, 7'h00, 7'h19, 7'h02, 7'h40};
        vecs[16] = '{1'b1, 4'd7, 1'b0, 1'b0, 4, 1'b1, 7'h78, 7'h00, 7'h19, 7'h02};

        // Power-on reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset seg", disp_bus.seg, 7'h7F);
        checkOutput("reset an", disp_bus.an, 4'hF);
        checkOutput("reset dp", disp_bus.dp, 1);
        checkOutput("reset fill_count", disp_bus.fill_count, 0);
        checkOutput("reset bad_input", disp_bus.bad_input, 0);
        checkOutput("reset wrap an", wrap_bus.an, 3'h7);
        rst = 1'b0;

        // Three-digit, every-cycle scan: an must run 6,5,3,6,... with no gap.
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checkOutput($sformatf("wrap an cycle%0d", k), wrap_bus.an, an3((cyc - 1) % 3));
        end

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d fill_count", i), disp_bus.fill_count, vecs[i].exp_fill);
            checkOutput($sformatf("vec%0d bad_input", i), disp_bus.bad_input, vecs[i].exp_bad);
            scanCheck($sformatf("vec%0d", i), vecs[i].bsy);
        end

        // Flash restart: let earlier flashes expire, then pick a start phase so
        // digit 0 is shown right after the first flash window would have ended.
        repeat (15) @(negedge clk);
        waited = 0;
        while ((((cyc + 10) / REFRESH_DIV) % NUM_DIGITS) != 0 && waited < 16) begin
            @(negedge clk);
            waited++;
        end
        disp_bus.result_valid = 1'b1;
        disp_bus.result_in    = 4'd4;
        for (int rel = 1; rel <= 24; rel++) begin
            @(negedge clk);
            if (rel == 1 || rel == 6) disp_bus.result_valid = 1'b0;
            if (rel == 5) disp_bus.result_valid = 1'b1;
            exp_digit = ((cyc - 1) / REFRESH_DIV) % NUM_DIGITS;
            // Second push lands on posedge 6, so dp may be lit up to 6+FLASH_CYCLES.
            exp_dp = (rel <= 6 + FLASH_CYCLES && exp_digit == 0) ? 1'b0 : 1'b1;
            checkOutput($sformatf("flash an rel%0d", rel), disp_bus.an, an4(exp_digit));
            checkOutput($sformatf("flash dp rel%0d", rel), disp_bus.dp, exp_dp);
        end

        // Mid-scan asynchronous reset with a full history and bad_input set.
        disp_bus.result_valid = 1'b1;
        disp_bus.result_in    = 4'hC;
        @(negedge clk);
        disp_bus.result_valid = 1'b0;
        checkOutput("pre-reset bad_input", disp_bus.bad_input, 1);
        checkOutput("pre-reset fill_count", disp_bus.fill_count, 4);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset seg", disp_bus.seg, 7'h7F);
        checkOutput("async reset an", disp_bus.an, 4'hF);
        checkOutput("async reset dp", disp_bus.dp, 1);
        checkOutput("async reset fill_count", disp_bus.fill_count, 0);
        checkOutput("async reset bad_input", disp_bus.bad_input, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (NUM_DIGITS) exp_q.push_back(7'h7F);
        scanCheck("post-reset", 1'b0);
        checkOutput("post-reset fill_count", disp_bus.fill_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
